multi_edge_detector: RTL and testbench
======================================

Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit edge detector.
- Each channel synchronises an asynchronous input and glitch-filters it over a programmable number of stable samples.
- Each channel then reports rising, falling or both edges, per its own mode, as a one-cycle pulse plus a sticky flag.
- A shared saturating counter tallies cycles with at least one reported edge; sits between raw GPIO/sensor pins and control FSMs.

Parameters:
- WIDTH, 8, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILTER_CYCLES, 4, consecutive synchronised samples required to accept a new level (>=1).
- CNT_W, 8, width of event_count.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data  input  WIDTH  asynchronous channel inputs.
- mode  input  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 disabled.
- clear  input  WIDTH  per-channel sticky clear, level-sampled.
- count_clear  input  1  synchronous clear of event_count.
- level  output  WIDTH  filtered, debounced level.
- edge_detect  output  WIDTH  one-cycle edge pulse per channel.
- edge_sticky  output  WIDTH  latched edge flags.
- any_edge  output  1  OR of edge_detect, same cycle.
- event_count  output  CNT_W  saturating count of any_edge cycles.

Behaviour:
- Reset (async, clock-independent) sets to 0: all synchroniser flops, filter counters, level, edge_detect, edge_sticky, any_edge, event_count.
- After release, a channel whose data is held 1 is treated as rising from level 0 and reports a rising edge after normal latency.

Synchroniser:
- Plain flop chain of SYNC_STAGES per channel.
- s_last is the final stage.

Filter (per channel, counter width clog2(FILTER_CYCLES)+1):
- s_last == level: counter <= 0.
- s_last != level and counter < FILTER_CYCLES-1: counter++.
- s_last != level and counter == FILTER_CYCLES-1: level <= s_last, counter <= 0.
- Any return of s_last to level before acceptance resets the counter; no edge is reported.

Latency:
- Take E1 as the first rising edge sampling the new data value (data stable thereafter).
- level changes, and edge_detect pulses, on edge E(SYNC_STAGES+FILTER_CYCLES); defaults give E6.

Edge qualification (registered, same edge as level update):
- edge_detect[i] = 1 for exactly one cycle when the level transition matches mode[i]: rising = 0->1, falling = 1->0, both = either.
- Mode 11: level still tracks, no pulse, no sticky set.
- mode is sampled on the update edge; a mode change never generates a pulse by itself.

Sticky flags:
- edge_sticky[i] sets on an edge_detect[i] pulse.
- clear[i]=1 clears it on the next edge.
- Simultaneous set and clear: set wins.

any_edge:
- Registered; equals OR of edge_detect in the same cycle.

event_count:
- Increments by 1 on each edge where any_edge is generated, visible the same cycle as the pulse.
- Saturates at 2^CNT_W-1.
- count_clear alone -> 0; count_clear with simultaneous increment -> 1.

Channels are fully independent; simultaneous edges on several channels give one count increment.

Decomposition:
- Package edge_det_pkg holds the mode encodings MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_OFF=2'b11, and a width helper for the filter counter.
- Sub-module edge_chan: one channel (synchroniser, filter, mode qualification, sticky), generated WIDTH times.
- Top holds any_edge and event_count.

Test Plan:
1. Reset, then data[0] 0->1 held, mode[1:0]=00, defaults: level[0] and edge_detect[0] rise on E6 after the first sampling edge; pulse 1 cycle; edge_sticky[0]=1; event_count=1.
2. Glitch: data[1] high for 3 clocks then low, mode=10: no edge_detect[1] and level[1] stays 0. A 4-clock-stable high then produces a pulse.
3. Falling and disabled modes:
   - ch2 mode 01: 0->1 gives no pulse, 1->0 gives a pulse.
   - ch3 mode 11: level follows, edge_detect[3] and edge_sticky[3] stay 0.
4. Simultaneous events:
   - data[7:4] toggle together in mode 10: four pulses in one cycle, any_edge=1, event_count +1 only.
   - clear[4] asserted on the pulse cycle leaves edge_sticky[4]=1; clear on the next cycle -> 0.
5. Saturation with CNT_W=2: 5 separated edges -> event_count 1,2,3,3,3. count_clear with an edge -> 1; count_clear alone -> 0.
6. Reset mid-operation: assert reset while a ch0 filter count is at 2 -> all outputs 0 immediately (asynchronous). Release with data[0]=1 -> rising pulse at E6 after release.

Source files
------------

// File: rtl/edge_det_pkg.sv
// -----------------------------------------------------------------------------
// edge_det_pkg
// Shared definitions for the multi-channel edge detector:
//   - edge_mode_e  : per-channel edge qualification mode encoding
//   - filt_cnt_w() : width of a channel's glitch-filter counter
//   - mode_match() : does an accepted level transition qualify under a mode
// -----------------------------------------------------------------------------
package edge_det_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } edge_mode_e;

    // Wide enough to hold FILTER_CYCLES-1 with headroom.
    function automatic int filt_cnt_w(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    // new_level is the level being accepted: 1 means a 0->1 transition.
    function automatic logic mode_match(input edge_mode_e mode, input logic new_level);
        logic hit;
        case (mode)
            MODE_RISE: hit = new_level;
            MODE_FALL: hit = !new_level;
            MODE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// -----------------------------------------------------------------------------
// edge_chan
// One detector channel: synchroniser chain, glitch filter, mode-qualified
// edge pulse and sticky flag.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   data          : asynchronous input pin
//   mode          : edge mode (see edge_mode_e)
//   clear         : sticky clear, sampled on the clock
//   level         : filtered level
//   edge_detect   : one-cycle pulse on a qualifying level change
//   edge_sticky   : latched edge flag
//   edge_next     : combinational value edge_detect will take on the next
//                   edge, so the parent can register any_edge alongside it
// -----------------------------------------------------------------------------
module edge_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data,
    input  logic [1:0] mode,
    input  logic       clear,
    output logic       level,
    output logic       edge_detect,
    output logic       edge_sticky,
    output logic       edge_next
);

    localparam int               FCW       = filt_cnt_w(FILTER_CYCLES);
    localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_last;
    logic [FCW-1:0]         filt_cnt_reg, filt_cnt_next;
    logic                   level_reg, level_next;
    logic                   accept;
    logic                   edge_reg;
    logic                   sticky_reg, sticky_next;

    assign s_last = sync_reg[SYNC_STAGES-1];

    // Synchroniser: data enters at bit 0, s_last leaves at the top.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], data};
        end
    end

    // Filter: a new level is accepted only after FILTER_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        filt_cnt_next = filt_cnt_reg;
        level_next    = level_reg;
        accept        = 1'b0;
        if (s_last == level_reg) begin
            filt_cnt_next = '0;
        end else if (filt_cnt_reg >= FILT_LAST) begin
            level_next    = s_last;
            filt_cnt_next = '0;
            accept        = 1'b1;
        end else begin
            filt_cnt_next = filt_cnt_reg + 1'b1;
        end
    end

    // Mode is only consulted on an accepted transition, so changing mode on
    // a quiet channel can never create a pulse.
    assign edge_next = accept & mode_match(edge_mode_e'(mode), s_last);

    // The flag picks up the registered pulse one edge later; a clear sampled
    // on that same edge loses to the set.
    assign sticky_next = edge_reg | (sticky_reg & ~clear);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_cnt_reg <= '0;
            level_reg    <= 1'b0;
            edge_reg     <= 1'b0;
            sticky_reg   <= 1'b0;
        end else begin
            filt_cnt_reg <= filt_cnt_next;
            level_reg    <= level_next;
            edge_reg     <= edge_next;
            sticky_reg   <= sticky_next;
        end
    end

    assign level       = level_reg;
    assign edge_detect = edge_reg;
    assign edge_sticky = sticky_reg;

endmodule

// File: rtl/multi_edge_detector.sv
// -----------------------------------------------------------------------------
// multi_edge_detector
// WIDTH independent edge_chan channels plus a shared any_edge flag and a
// saturating counter of cycles carrying at least one edge pulse.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   data          : asynchronous channel inputs
//   mode          : per-channel mode, bits [2i+1:2i]
//   clear         : per-channel sticky clear
//   count_clear   : synchronous clear of event_count
//   level         : filtered levels
//   edge_detect   : one-cycle edge pulses
//   edge_sticky   : latched edge flags
//   any_edge      : OR of edge_detect, same cycle
//   event_count   : saturating count of any_edge cycles
// -----------------------------------------------------------------------------
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clear,
    input  logic                 count_clear,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     edge_detect,
    output logic [WIDTH-1:0]     edge_sticky,
    output logic                 any_edge,
    output logic [CNT_W-1:0]     event_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] edge_next;
    logic             any_edge_reg, any_edge_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            edge_chan #(
                .SYNC_STAGES   (SYNC_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES)
            ) u_chan (
                .clock       (clock),
                .reset       (reset),
                .data        (data[gi]),
                .mode        (mode[2*gi+1 -: 2]),
                .clear       (clear[gi]),
                .level       (level[gi]),
                .edge_detect (edge_detect[gi]),
                .edge_sticky (edge_sticky[gi]),
                .edge_next   (edge_next[gi])
            );
        end
    endgenerate

    // Built from the channels' next-pulse terms so any_edge and the count
    // update land on the same edge as the pulses themselves.
    assign any_edge_next = |edge_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (count_clear) begin
            cnt_next = any_edge_next ? CNT_W'(1) : '0;
        end else if (any_edge_next && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            any_edge_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            any_edge_reg <= any_edge_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign any_edge    = any_edge_reg;
    assign event_count = cnt_reg;

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  data;
    logic [15:0] mode;
    logic [7:0]  clear;
    logic        count_clear;
    logic [7:0]  level;
    logic [7:0]  edge_detect;
    logic [7:0]  edge_sticky;
    logic        any_edge;
    logic [1:0]  event_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] ed;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    multi_edge_detector #(
        .WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_W(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data        (data),
        .mode        (mode),
        .clear       (clear),
        .count_clear (count_clear),
        .level       (level),
        .edge_detect (edge_detect),
        .edge_sticky (edge_sticky),
        .any_edge    (any_edge),
        .event_count (event_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, got, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expect a pulse dly edges after the current point (called right after
    // driving the stimulus, so edge 1 is the first edge sampling it).
    task automatic push(input int dly, input logic [7:0] ed, input logic [1:0] cnt);
        exp_t e;
        e.cyc = cyc + dly;
        e.ed  = ed;
        e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle presenting an edge pops one expectation.
    always @(negedge clock) begin
        if (!reset && (any_edge || (edge_detect != 8'h00))) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_edge: edge_detect=%0h any_edge=%0b required none (cycle %0d)",
                         edge_detect, any_edge, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("edge_detect", {24'd0, edge_detect}, {24'd0, e.ed});
                chk("any_edge", {31'd0, any_edge}, 32'd1);
                chk("event_count", {30'd0, event_count}, {30'd0, e.cnt});
            end
        end
    end

    initial begin
        reset       = 1'b1;
        data        = 8'h00;
        // ch0 rise, ch1 both, ch2 fall, ch3 off, ch4..7 both
        mode        = 16'hAAD8;
        clear       = 8'h00;
        count_clear = 1'b0;

        #12;
        chk("rst_level",  {24'd0, level},       32'd0);
        chk("rst_edge",   {24'd0, edge_detect}, 32'd0);
        chk("rst_sticky", {24'd0, edge_sticky}, 32'd0);
        chk("rst_any",    {31'd0, any_edge},    32'd0);
        chk("rst_count",  {30'd0, event_count}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // 1: ch0 rising, pulse on E6
        tick(2);
        data[0] = 1'b1;
        push(6, 8'h01, 2'd1);
        tick(5);
        chk("t1_level_e5", {31'd0, level[0]}, 32'd0);
        tick(1);
        chk("t1_level_e6", {31'd0, level[0]}, 32'd1);
        tick(1);
        chk("t1_pulse_gone", {24'd0, edge_detect}, 32'd0);
        chk("t1_sticky", {31'd0, edge_sticky[0]}, 32'd1);

        // 2: 3-clock glitch rejected, 4-clock high accepted (both edges)
        tick(2);
        data[1] = 1'b1;
        tick(3);
        data[1] = 1'b0;
        tick(8);
        chk("t2_glitch_level", {31'd0, level[1]}, 32'd0);
        data[1] = 1'b1;
        push(6, 8'h02, 2'd2);
        push(10, 8'h02, 2'd3);
        tick(4);
        data[1] = 1'b0;
        tick(10);
        chk("t2_level_back", {31'd0, level[1]}, 32'd0);

        count_clear = 1'b1;
        tick(1);
        count_clear = 1'b0;
        chk("t2_count_clear", {30'd0, event_count}, 32'd0);

        // 3: ch2 falling-only, ch3 disabled
        data[2] = 1'b1;
        tick(10);
        chk("t3_ch2_level_hi", {31'd0, level[2]}, 32'd1);
        chk("t3_ch2_sticky", {31'd0, edge_sticky[2]}, 32'd0);
        data[2] = 1'b0;
        push(6, 8'h04, 2'd1);
        tick(8);
        chk("t3_ch2_level_lo", {31'd0, level[2]}, 32'd0);
        data[3] = 1'b1;
        tick(8);
        chk("t3_ch3_level_hi", {31'd0, level[3]}, 32'd1);
        data[3] = 1'b0;
        tick(8);
        chk("t3_ch3_level_lo", {31'd0, level[3]}, 32'd0);
        chk("t3_ch3_sticky", {31'd0, edge_sticky[3]}, 32'd0);

        // 4: four channels at once, one count; clear vs set on ch4
        data[7:4] = 4'hF;
        push(6, 8'hF0, 2'd2);
        tick(6);
        clear[4] = 1'b1;
        tick(1);
        chk("t4_sticky_set_wins", {28'd0, edge_sticky[7:4]}, 32'hF);
        tick(1);
        chk("t4_sticky_cleared", {28'd0, edge_sticky[7:4]}, 32'hE);
        clear[4] = 1'b0;
        data[7:4] = 4'h0;
        push(6, 8'hF0, 2'd3);
        tick(8);

        // 5: saturation 1,2,3,3,3 on ch1 toggles
        count_clear = 1'b1;
        tick(1);
        count_clear = 1'b0;
        chk("t5_clear0", {30'd0, event_count}, 32'd0);
        data[1] = 1'b1; push(6, 8'h02, 2'd1); tick(8);
        data[1] = 1'b0; push(6, 8'h02, 2'd2); tick(8);
        data[1] = 1'b1; push(6, 8'h02, 2'd3); tick(8);
        data[1] = 1'b0; push(6, 8'h02, 2'd3); tick(8);
        data[1] = 1'b1; push(6, 8'h02, 2'd3); tick(8);
        count_clear = 1'b1;
        tick(1);
        count_clear = 1'b0;
        chk("t5_clear_alone", {30'd0, event_count}, 32'd0);
        data[1] = 1'b0;
        push(6, 8'h02, 2'd1);
        tick(5);
        count_clear = 1'b1;
        tick(1);
        count_clear = 1'b0;
        chk("t5_clear_with_edge", {30'd0, event_count}, 32'd1);
        tick(3);

        // 6: async reset while ch0 filter is mid-count
        data[0] = 1'b0;
        tick(4);
        #1 reset = 1'b1;
        #1;
        chk("t6_level",  {24'd0, level},       32'd0);
        chk("t6_sticky", {24'd0, edge_sticky}, 32'd0);
        chk("t6_count",  {30'd0, event_count}, 32'd0);
        chk("t6_any",    {31'd0, any_edge},    32'd0);
        tick(1);
        reset = 1'b0;
        data  = 8'h01;
        push(6, 8'h01, 2'd1);
        tick(10);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
